// File: rtl/irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_ctrl : 8-bit bus interrupt controller (mask, edge/level, vector, ack) |
// | Optional IRQC_SYNC_EN: 2-flop synchroniser on every src input.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module irq_ctrl #(
   parameter logic [7:0] BASE_ADDR = 8'h94,
   parameter logic [7:0] LAST_ADDR = 8'h97,
   parameter int         NUM_SRC   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         addr,
   input  logic [7:0]         dout,
   output logic [7:0]         din,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [NUM_SRC-1:0] src,
   output logic               irq
);

   localparam logic [1:0] c_off_pend   = 2'd0;
   localparam logic [1:0] c_off_mask   = 2'd1;
   localparam logic [1:0] c_off_mode   = 2'd2;
   localparam logic [1:0] c_off_vector = 2'd3;

   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] mode_q, mode_d;
   logic [NUM_SRC-1:0] src_d_q, src_d_d;
   logic               irq_q, irq_d;

   logic [NUM_SRC-1:0] w_s;
   logic [NUM_SRC-1:0] w_set;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_active;
   logic               w_sel;
   logic [1:0]         w_off;
   logic [2:0]         w_idx;
   logic               w_unused;

   assign w_sel    = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
   // The window is exactly four bytes, so the low two bits give the offset.
   assign w_off    = addr[1:0] - BASE_ADDR[1:0];
   assign w_unused = ^dout;

`ifdef IRQC_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q, sync1_d;
   logic [NUM_SRC-1:0] sync2_q, sync2_d;

   always_comb begin
      sync1_d = src;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign w_s = sync2_q;
`else
   assign w_s = src;
`endif

   always_comb begin
      // Edge-mode bits need a 0->1 transition; level-mode bits set whenever high.
      w_set   = w_s & (~mode_q | ~src_d_q);
      w_clr   = '0;
      mask_d  = mask_q;
      mode_d  = mode_q;
      src_d_d = w_s;
      if (wr_en && w_sel) begin
         case (w_off)
            c_off_pend: w_clr  = dout[NUM_SRC-1:0];
            c_off_mask: mask_d = dout[NUM_SRC-1:0];
            c_off_mode: mode_d = dout[NUM_SRC-1:0];
            default: begin
               for (int i = 0; i < NUM_SRC; i++) begin
                  w_clr[i] = (dout[2:0] == 3'(i));
               end
            end
         endcase
      end
      pend_d   = (pend_q & ~w_clr) | w_set;
      w_active = pend_q & mask_q;
      irq_d    = |w_active;
   end

   always_comb begin
      w_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_active[i]) begin
            w_idx = 3'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q  <= '0;
         mask_q  <= '0;
         mode_q  <= '0;
         src_d_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         src_d_q <= src_d_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      din = 8'h00;
      if (rd_en && w_sel) begin
         case (w_off)
            c_off_pend:   din = 8'(pend_q);
            c_off_mask:   din = 8'(mask_q);
            c_off_mode:   din = 8'(mode_q);
            c_off_vector: din = irq_d ? {1'b1, 4'b0000, w_idx} : 8'h00;
            default:      din = 8'h00;
         endcase
      end
   end

   assign irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_irq_ctrl : directed stimulus, per-cycle model compare, literal pins    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_irq_ctrl;

   localparam int         NUM_SRC = 4;
   localparam logic [7:0] BASE    = 8'h94;
`ifdef IRQC_SYNC_EN
   localparam int SYNC_STAGES = 2;
`else
   localparam int SYNC_STAGES = 0;
`endif

   logic               clk   = 1'b0;
   logic               reset = 1'b1;
   logic [7:0]         addr  = 8'h00;
   logic [7:0]         dout  = 8'h00;
   logic [7:0]         din;
   logic               wr_en = 1'b0;
   logic               rd_en = 1'b0;
   logic [NUM_SRC-1:0] src   = '0;
   logic               irq;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   irq_ctrl #(.BASE_ADDR(8'h94), .LAST_ADDR(8'h97), .NUM_SRC(NUM_SRC)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .dout  (dout),
      .din   (din),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .src   (src),
      .irq   (irq)
   );

   // Reference state: one flag per source, updated from the register-map rules.
   bit m_pend[NUM_SRC];
   bit m_mask[NUM_SRC];
   bit m_mode[NUM_SRC];
   bit m_prev[NUM_SRC];
   bit m_sy1[NUM_SRC];
   bit m_sy2[NUM_SRC];
   bit m_irq;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         foreach (m_pend[i]) begin
            m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = 0;
            m_prev[i] = 0; m_sy1[i] = 0;  m_sy2[i] = 0;
         end
         m_irq = 0;
      end else begin
         bit s[NUM_SRC];
         bit any;
         bit hit;
         int off;
         any = 0;
         foreach (m_pend[i]) if (m_pend[i] && m_mask[i]) any = 1;
         m_irq = any;
         hit = wr_en && (addr >= BASE) && (addr <= BASE + 8'd3);
         off = int'(addr) - int'(BASE);
         for (int i = 0; i < NUM_SRC; i++) begin
            bit set_i;
            bit clr_i;
            s[i]  = (SYNC_STAGES == 0) ? src[i] : m_sy2[i];
            set_i = m_mode[i] ? (s[i] && !m_prev[i]) : s[i];
            clr_i = hit && ((off == 0 && dout[i]) || (off == 3 && int'(dout[2:0]) == i));
            if (set_i)      m_pend[i] = 1;
            else if (clr_i) m_pend[i] = 0;
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            if (hit && off == 1) m_mask[i] = dout[i];
            if (hit && off == 2) m_mode[i] = dout[i];
            m_prev[i] = s[i];
            m_sy2[i]  = m_sy1[i];
            m_sy1[i]  = src[i];
         end
      end
   end

   function automatic logic [7:0] exp_din(input logic [7:0] a, input logic re);
      logic [7:0] r;
      r = 8'h00;
      if (re && a >= BASE && a <= BASE + 8'd3) begin
         case (a - BASE)
            8'd0: for (int i = 0; i < NUM_SRC; i++) r[i] = m_pend[i];
            8'd1: for (int i = 0; i < NUM_SRC; i++) r[i] = m_mask[i];
            8'd2: for (int i = 0; i < NUM_SRC; i++) r[i] = m_mode[i];
            default: begin
               for (int i = 0; i < NUM_SRC; i++) begin
                  if (m_pend[i] && m_mask[i]) begin
                     r = 8'h80 + 8'(i);
                     break;
                  end
               end
            end
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en && !reset) begin
         chk("model_din", din, exp_din(addr, rd_en));
         chk("model_irq", {7'b0, irq}, {7'b0, m_irq});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      repeat (SYNC_STAGES) tick();
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      addr = a; dout = d; wr_en = 1'b1; rd_en = 1'b0;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] e);
      addr = a; rd_en = 1'b1; wr_en = 1'b0;
      @(negedge clk);
      chk(nm, din, e);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic irq_chk(input string nm, input logic e);
      @(negedge clk);
      chk(nm, {7'b0, irq}, {7'b0, e});
      tick();
   endtask

   initial begin
      int lat;
      repeat (3) tick();
      reset  = 1'b0;
      cmp_en = 1'b1;

      // Reset state and idle read
      rd_chk("rst_pend",   8'h94, 8'h00);
      rd_chk("rst_mask",   8'h95, 8'h00);
      rd_chk("rst_mode",   8'h96, 8'h00);
      rd_chk("rst_vector", 8'h97, 8'h00);
      addr = 8'h94; rd_en = 1'b0;
      @(negedge clk);
      chk("idle_din", din, 8'h00);
      chk("rst_irq", {7'b0, irq}, 8'h00);
      tick();

      // Level-mode single-cycle pulse on src[2]
      wr(8'h95, 8'h0F);
      wr(8'h96, 8'h00);
      src = 4'b0100;
      tick();
      src = 4'b0000;
      settle();
      irq_chk("irq_lat0", 1'b0);
      irq_chk("irq_lat1", 1'b1);
      rd_chk("pulse_pend",   8'h94, 8'h04);
      rd_chk("pulse_vector", 8'h97, 8'h82);
      wr(8'h94, 8'h04);
      irq_chk("irq_hold", 1'b1);
      irq_chk("irq_drop", 1'b0);
      rd_chk("w1c_pend", 8'h94, 8'h00);

      // Edge mode: long high on src[0] latches only once
      wr(8'h96, 8'h0F);
      src = 4'b0001;
      repeat (3) tick();
      settle();
      rd_chk("edge_set", 8'h94, 8'h01);
      wr(8'h94, 8'h01);
      rd_chk("edge_clr", 8'h94, 8'h00);
      repeat (5) tick();
      rd_chk("edge_hold", 8'h94, 8'h00);
      src = 4'b0000;
      tick();
      src = 4'b0001;
      tick();
      settle();
      rd_chk("edge_again", 8'h94, 8'h01);
      wr(8'h94, 8'h01);
      src = 4'b0000;
      settle();
      tick();

      // Priority and vector acknowledge
      wr(8'h95, 8'h0A);
      src = 4'b1010;
      tick();
      tick();
      settle();
      rd_chk("vec_first", 8'h97, 8'h81);
      wr(8'h97, 8'h07);
      rd_chk("vec_oob_ack", 8'h97, 8'h81);
      wr(8'h97, 8'h01);
      rd_chk("vec_second", 8'h97, 8'h83);
      wr(8'h97, 8'h03);
      rd_chk("vec_empty", 8'h97, 8'h00);
      irq_chk("vec_irq_low", 1'b0);
      src = 4'b0000;
      settle();
      tick();

      // Level mode: set wins over same-edge clear; upper mask bits ignored
      wr(8'h96, 8'h00);
      wr(8'h95, 8'h0F);
      src = 4'b0010;
      tick();
      tick();
      settle();
      wr(8'h94, 8'h02);
      rd_chk("set_wins", 8'h94, 8'h02);
      wr(8'h95, 8'hF0);
      rd_chk("mask_upper", 8'h95, 8'h00);

      // Asynchronous reset with irq asserted
      wr(8'h95, 8'h02);
      repeat (2) tick();
      @(negedge clk);
      chk("pre_reset_irq", {7'b0, irq}, 8'h01);
      #2 reset = 1'b1;
      #1 chk("async_irq", {7'b0, irq}, 8'h00);
      rd_en = 1'b1;
      for (int o = 0; o < 4; o++) begin
         addr = BASE + 8'(o);
         #0.5;
         chk("reset_regs", din, 8'h00);
      end
      rd_en = 1'b0;
      src   = 4'b0000;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Source rise to irq latency
      wr(8'h95, 8'h01);
      src = 4'b0001;
      lat = 0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (irq) begin
            lat = n;
            break;
         end
      end
      chk("latency", 8'(lat), 8'(2 + SYNC_STAGES));
      tick();
      src = 4'b0000;
      repeat (4) tick();
      wr(8'h94, 8'h0F);
      repeat (2) tick();

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller on the 8-bit peripheral bus.
- Collects up to 8 peripheral interrupt sources into the single CPU `irq_ip` input, which is currently tied to 0.
- Per-source mask, per-source edge/level mode, sticky pending bits, and a fixed-priority vector register with write-to-acknowledge.
- Instantiated alongside the gpio, spi and iic blocks; its `irq` output drives the CPU directly.

Parameters:
- BASE_ADDR, 8'h94, first register address.
- LAST_ADDR, 8'h97, last register address; must equal BASE_ADDR+3.
- NUM_SRC, 4, number of interrupt sources, legal range 1..8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- addr  in  8  CPU bus address
- dout  in  8  CPU write data
- din  out  8  read data to CPU
- wr_en  in  1  CPU write strobe, one cycle per access
- rd_en  in  1  CPU read strobe
- src  in  NUM_SRC  interrupt request inputs from peripherals, active-high
- irq  out  1  interrupt request to CPU, active-high

Behaviour:
- Decode: a bus access is selected when BASE_ADDR <= addr <= LAST_ADDR. Register offset = addr - BASE_ADDR.
- Register map:
  - 0 PEND: read gives pending bits; writing 1 clears that bit (W1C), writing 0 has no effect.
  - 1 MASK: R/W; 1 enables the source.
  - 2 MODE: R/W; 1 = rising-edge sensitive, 0 = level sensitive.
  - 3 VECTOR: read gives {valid, 4'b0, idx[2:0]}; a write acknowledges source dout[2:0], clearing its PEND bit.
- Bits at or above NUM_SRC read 0 and ignore writes. A VECTOR write with dout[2:0] >= NUM_SRC has no effect.
- din is combinational: register contents when rd_en is high and the address is selected, else 8'h00. Read-side effects: none.
- s denotes the source sample: raw src, or the synchroniser output (see Optional Feature). src_d is s registered once.
- Edge mode: a PEND bit is set at the clock edge where s=1 and src_d=0.
- Level mode: a PEND bit is set at every clock edge where s=1. After a clear it re-sets on the next edge if the source is still high.
- Same-edge set and clear (W1C or VECTOR ack): set wins and the bit stays 1.
- Changing a MODE bit takes effect at the next edge. Existing PEND bits are kept.
- Priority: the lowest index among (PEND & MASK) wins.
  - VECTOR = {1'b1, 4'b0, idx} when any bit is pending and enabled, else 8'h00.
- irq is registered as irq <= |(PEND & MASK). It is high one cycle after the enabling PEND/MASK state and low one cycle after the last enabled pending bit clears.
- Masked sources still latch PEND, so unmasking a pending source raises irq one cycle later.
- Reset (asynchronous, any time including mid-transaction): PEND, MASK, MODE, src_d and synchroniser flops = 0, irq = 0 immediately. din then follows the combinational rule.
- Latency without the feature: src goes high before edge k → PEND set at edge k → irq high after edge k+1.

Optional Feature:
- IRQC_SYNC_EN defined:
  - Each src bit passes through a 2-flop synchroniser (reset 0), so s is the second flop.
  - All latencies grow by 2 cycles: PEND set at edge k+2, irq high after edge k+3.
- IRQC_SYNC_EN undefined:
  - s = src directly; sources must be synchronous to clk.

Test Plan:
- Reset, then read offsets 0..3 → all 8'h00; irq=0. Read with rd_en=0 at 8'h94 → din=8'h00.
- NUM_SRC=4, MODE=0, MASK=8'h0F, pulse src[2] for 1 cycle → PEND=8'h04, VECTOR=8'h82, irq=1 after one cycle; write 8'h04 to PEND → PEND=0, irq drops next cycle.
- MODE=8'h0F, hold src[0] high for 10 cycles → PEND[0] set once; W1C clears it and it stays 0 while src holds; src low then high → set again.
- MASK=8'h0A, src[3] and src[1] rise on the same cycle → VECTOR=8'h81; write VECTOR 8'h01 → VECTOR=8'h83; write 8'h03 → VECTOR=8'h00, irq=0.
- Level mode, src[1] held high, W1C on PEND bit 1 → PEND[1] reads 1 again on the next cycle (set wins); a write of 8'hF0 to MASK reads back 8'h00.
- Assert reset mid-pending with irq=1 → irq=0 without a clock edge and all registers read 0. With IRQC_SYNC_EN defined, src rise-to-irq delay is exactly 2 cycles longer than without.
